add_seq_ctrl: RTL and testbench
===============================

// Module: add_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer that computes a WIDTH-bit sum with one shared SLICE-bit adder slice, LSB slice first.
//  The slice carry is registered between cycles, so carry-in (cin) and carry-out (cout) are fully honoured.
//  Sits between a valid/ready producer and consumer in the lab arithmetic datapath.
//  Trades latency for area against the flat 32-bit adder.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  SLICE  16  adder slice width in bits; WIDTH % SLICE must be 0, otherwise elaboration error
//  NSL    WIDTH/SLICE  (localparam) number of slice cycles per operation
// PORTS
//  clk        in   1      single clock; all state updates on its rising edge
//  rst_n      in   1      reset: synchronous and active-low
//  in_valid   in   1      operand request valid
//  in_ready   out  1      block can accept operands this cycle
//  a          in   WIDTH  operand A, sampled on the accept cycle only
//  b          in   WIDTH  operand B, sampled on the accept cycle only
//  cin        in   1      carry into bit 0, sampled on the accept cycle only
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n == 0 at a clk edge):
//   - state=IDLE; out_valid=0, sum=0, cout=0, busy=0; internal carry and slice index cleared.
//   - Applies mid-operation: the operation is aborted silently and no result is produced.
//  FSM states:
//   - IDLE: in_ready=1. On in_valid & in_ready, register a, b, cin; idx=0; go to RUN.
//   - RUN: each cycle add slice idx: {c, s} = a[idx] + b[idx] + carry.
//     s is written to sum[idx*SLICE +: SLICE]; carry <= c; idx++.
//     After slice NSL-1 is added: cout <= c; go to DONE.
//     in_ready=0; in_valid is ignored.
//   - DONE: out_valid=1. sum and cout are held stable until the transfer (out_valid & out_ready).
//  Leaving DONE:
//   - Transfer without a new accept: go to IDLE, out_valid=0.
//   - in_ready = out_ready in DONE, so a new request can be accepted in the same cycle as the transfer (back-to-back).
//   - On simultaneous transfer + accept: load the new operands and go directly to RUN.
//  Timing:
//   - Latency: accept at edge E, out_valid high after edge E+NSL.
//   - Throughput: one result per NSL+1 cycles with no backpressure (DONE occupies one cycle).
//  Width rules:
//   - The slice adder is SLICE+1 bits wide.
//   - Overflow wraps modulo 2^WIDTH and is reported on cout.
//   - NSL == 1 is legal: RUN lasts one cycle.
//  Registers:
//   - sum is updated only in RUN and is not cleared between operations.
//   - Outside DONE its value is don't-care for the consumer.
//   - idx width = max(1, $clog2(NSL)).
// STRUCTURE
//  Shared package arith_pkg:
//   - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
//   - Default WIDTH/SLICE constants.
//  Sub-module add_slice (SLICE-bit adder, ports a, b, ci, s, co):
//   - Purely combinational, one instance.
//  This module contains the FSM, operand registers, carry register, slice mux and result register.
// TESTING
//  1. a=32'h0000FFFF, b=32'h00000001, cin=0
//     -> sum=32'h00010000, cout=0; out_valid 2 cycles after accept.
//  2. a=32'hFFFFFFFF, b=0, cin=1 -> sum=0, cout=1.
//     Also a=32'h80000000, b=32'h80000000 -> sum=0, cout=1.
//  3. Hold out_ready=0 for 5 cycles in DONE
//     -> sum, cout, out_valid stable; in_ready=0; in_valid pulses ignored.
//  4. rst_n=0 for one cycle during RUN (idx=1) -> out_valid never rises for that op.
//     The next op (a=3, b=4, cin=1) gives sum=8.
//  5. Back-to-back: in_valid and out_ready held high with 4 operand pairs
//     -> results in order, each 3 cycles apart.
//     Also scoreboard against a+b+cin with 1000 random vectors.
//  6. Parameter sweep (WIDTH, SLICE) = (32,8), (32,32), (64,16): NSL-cycle latency and results match the model.

Source files
------------

// File: rtl/add_seq_ctrl_pkg.sv
// Shared arithmetic definitions for the sliced add sequencer.
package arith_pkg;

  // Sequencer states; encodings are fixed for debug visibility.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 16;

  // Slice index width; a single-slice configuration still needs one bit.
  function automatic int unsigned idx_width(input int unsigned nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_slice.sv
// SLICE-bit ripple adder slice with carry in and carry out.
module add_slice #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  logic [SLICE:0] full;

  // One SLICE+1 bit add; the top bit is the slice carry.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
    s    = full[SLICE-1:0];
    co   = full[SLICE];
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared SLICE-bit slice, LSB slice first,
// carry registered between slices, valid/ready on both sides.
module add_seq_ctrl
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSL = WIDTH / SLICE;
  localparam int unsigned IW  = idx_width(NSL);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  if ((SLICE == 0) || (WIDTH % SLICE != 0)) begin : g_bad_cfg
    $error("add_seq_ctrl: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e                    state_q;
  logic [NSL-1:0][SLICE-1:0] a_q;
  logic [NSL-1:0][SLICE-1:0] b_q;
  logic [NSL-1:0][SLICE-1:0] sum_q;
  logic                      carry_q;
  logic                      cout_q;
  logic                      out_valid_q;
  logic [IW-1:0]             idx_q;
  logic [IW-1:0]             idx_d;

  logic [SLICE-1:0]          sl_a;
  logic [SLICE-1:0]          sl_b;
  logic [SLICE-1:0]          sl_s;
  logic                      sl_co;

  // Ready in IDLE, and in DONE only when the result leaves this cycle.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Select the operand slices for the current index.
  always_comb begin
    sl_a  = a_q[idx_q];
    sl_b  = b_q[idx_q];
    idx_d = idx_q + IW'(1);
  end

  add_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  // Sequencer FSM with operand, carry, index and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q] <= sl_s;
          carry_q      <= sl_co;
          if (idx_q == LAST_IDX) begin
            cout_q      <= sl_co;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            // Transfer and new accept in one cycle skip IDLE entirely.
            if (in_valid) begin
              a_q     <= a;
              b_q     <= b;
              carry_q <= cin;
              idx_q   <= '0;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: vector table, corner sequences,
// streaming scoreboard and a parameter sweep.
module tb_add_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [31:0] a, b, sum;

  add_seq_ctrl #(.WIDTH(32), .SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  // Sweep instances share one stimulus set.
  logic        sw_valid, sw_oready, sw_cin;
  logic [63:0] sw_a, sw_b;
  logic        r8, v8, c8, bz8, r32, v32, c32, bz32, r64, v64, c64, bz64;
  logic [31:0] s8, s32;
  logic [63:0] s64;

  add_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8),
    .a(sw_a[31:0]), .b(sw_b[31:0]), .cin(sw_cin), .out_valid(v8),
    .out_ready(sw_oready), .sum(s8), .cout(c8), .busy(bz8)
  );
  add_seq_ctrl #(.WIDTH(32), .SLICE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r32),
    .a(sw_a[31:0]), .b(sw_b[31:0]), .cin(sw_cin), .out_valid(v32),
    .out_ready(sw_oready), .sum(s32), .cout(c32), .busy(bz32)
  );
  add_seq_ctrl #(.WIDTH(64), .SLICE(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(v64),
    .out_ready(sw_oready), .sum(s64), .cout(c64), .busy(bz64)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[7];

  // Accept one operand set from IDLE and wait for out_valid (no transfer).
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                        output logic [31:0] rsum, output logic rcout, output int lat);
    a = oa; b = ob; cin = oc; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    rsum  = sum;
    rcout = cout;
  endtask

  task automatic transfer();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Valid/ready stream scored against plain a+b+cin arithmetic.
  task automatic stream(input int n_ops, input bit rnd, input bit spacing);
    logic [32:0] q[$];
    logic [32:0] exp;
    logic [31:0] na, nb;
    logic        nc, acc;
    int sent = 0, got = 0, cyc = 0, last = -1;
    na = $urandom; nb = $urandom; nc = 1'($urandom_range(0, 1));
    while (got < n_ops && cyc < n_ops * 12 + 50) begin
      in_valid  = (sent < n_ops) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      a = na; b = nb; cin = nc;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream_unexpected_result", 1, 0);
        end else begin
          exp = q.pop_front();
          check("stream_sum", sum, exp[31:0]);
          check("stream_cout", cout, exp[32]);
        end
        if (spacing && last >= 0) check("stream_spacing", cyc - last, 3);
        last = cyc;
        got++;
      end
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        q.push_back({1'b0, na} + {1'b0, nb} + 33'(nc));
        sent++;
        na = $urandom; nb = $urandom; nc = 1'($urandom_range(0, 1));
      end
    end
    if (got < n_ops) check("stream_timeout", got, n_ops);
    in_valid = 1'b0; out_ready = 1'b0;
    step();
  endtask

  // One operation on all sweep instances; latency and result per instance.
  task automatic sweep_op(input logic [63:0] oa, input logic [63:0] ob, input logic oc);
    logic [32:0] ref32;
    logic [64:0] ref64;
    logic [31:0] g8, g32;
    logic [63:0] g64;
    logic        k8, k32, k64;
    int l8 = 0, l32 = 0, l64 = 0;
    g8 = '0; g32 = '0; g64 = '0; k8 = 1'b0; k32 = 1'b0; k64 = 1'b0;
    ref32 = {1'b0, oa[31:0]} + {1'b0, ob[31:0]} + 33'(oc);
    ref64 = {1'b0, oa} + {1'b0, ob} + 65'(oc);
    sw_a = oa; sw_b = ob; sw_cin = oc; sw_valid = 1'b1; sw_oready = 1'b1;
    step();
    sw_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (v8 && l8 == 0)   begin l8 = c;  g8 = s8;   k8 = c8;   end
      if (v32 && l32 == 0) begin l32 = c; g32 = s32; k32 = c32; end
      if (v64 && l64 == 0) begin l64 = c; g64 = s64; k64 = c64; end
    end
    check("sweep_lat_32_8", l8, 4);
    check("sweep_lat_32_32", l32, 1);
    check("sweep_lat_64_16", l64, 4);
    check("sweep_sum_32_8", g8, ref32[31:0]);
    check("sweep_cout_32_8", k8, ref32[32]);
    check("sweep_sum_32_32", g32, ref32[31:0]);
    check("sweep_cout_32_32", k32, ref32[32]);
    check("sweep_sum_64_16", g64, ref64[63:0]);
    check("sweep_cout_64_16", k64, ref64[64]);
  endtask

  initial begin
    logic [31:0] rs;
    logic        rc, seen;
    int          lat;

    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[3] = '{32'h00000003, 32'h00000004, 1'b1, 32'h00000008, 1'b0};
    vecs[4] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
    vecs[5] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1};
    vecs[6] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    sw_valid = 1'b0; sw_oready = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Vector table: latency, result, and return to IDLE after transfer.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_sum", i), rs, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), rc, vecs[i].cout);
      transfer();
      check($sformatf("vec%0d_valid_drop", i), out_valid, 0);
      check($sformatf("vec%0d_idle", i), busy, 0);
    end

    // Backpressure in DONE: outputs hold, new requests ignored.
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, rs, rc, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = $urandom; b = $urandom; cin = 1'b1;
      step();
      check("hold_sum", sum, 32'hACF13569);
      check("hold_cout", cout, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    transfer();
    check("hold_release_valid", out_valid, 0);
    step(); step(); step();
    check("hold_no_ghost_op", busy, 0);

    // Reset mid-operation (idx=1): op is dropped, then a fresh op works.
    a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("run_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    run_op(32'd3, 32'd4, 1'b1, rs, rc, lat);
    check("post_abort_sum", rs, 32'd8);
    check("post_abort_latency", lat, 2);
    transfer();

    stream(4, 1'b0, 1'b1);
    stream(1000, 1'b1, 1'b0);

    sweep_op({64{1'b1}}, 64'd0, 1'b1);
    sweep_op(64'h8000000080000000, 64'h8000000080000000, 1'b0);
    for (int i = 0; i < 8; i++)
      sweep_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
